// File: rtl/elevator_display_ctrl_pkg.sv
// elevator_display_ctrl_pkg: shared symbol codes, status encodings and the
// animation state type used by the display sequencer and the SSD decoder.
//   Contents: CODE_* symbol codes, MOTION_*/DOOR_* input encodings, anim_e,
//   and small helpers that map status to symbol codes.
package elevator_display_ctrl_pkg;

    localparam logic [3:0] CODE_OPEN   = 4'd0;
    localparam logic [3:0] CODE_UP_PTR = 4'd5;
    localparam logic [3:0] CODE_DASH   = 4'd6;
    localparam logic [3:0] CODE_DN_PTR = 4'd7;
    localparam logic [3:0] CODE_BAR_HI = 4'd10;
    localparam logic [3:0] CODE_BAR_LO = 4'd11;
    localparam logic [3:0] CODE_CLOSE  = 4'd12;
    localparam logic [3:0] CODE_BLANK  = 4'd15;

    localparam logic [1:0] MOTION_IDLE = 2'b00;
    localparam logic [1:0] MOTION_UP   = 2'b01;
    localparam logic [1:0] MOTION_DOWN = 2'b10;

    localparam logic [1:0] DOOR_CLOSED  = 2'b00;
    localparam logic [1:0] DOOR_OPEN    = 2'b01;
    localparam logic [1:0] DOOR_OPENING = 2'b10;
    localparam logic [1:0] DOOR_CLOSING = 2'b11;

    typedef enum logic [1:0] {
        ANIM_LOW  = 2'd0,
        ANIM_MID  = 2'd1,
        ANIM_HIGH = 2'd2
    } anim_e;

    // The reserved motion code 11 behaves exactly like idle everywhere.
    function automatic logic [1:0] motion_norm(input logic [1:0] m);
        return (m == 2'b11) ? MOTION_IDLE : m;
    endfunction

    function automatic logic [3:0] door_code(input logic [1:0] door, input logic blink);
        case (door)
            DOOR_CLOSED:  return CODE_CLOSE;
            DOOR_OPEN:    return CODE_OPEN;
            DOOR_OPENING: return blink ? CODE_BLANK : CODE_OPEN;
            DOOR_CLOSING: return blink ? CODE_BLANK : CODE_CLOSE;
            default:      return CODE_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] bar_code(input anim_e s);
        return (s == ANIM_LOW) ? CODE_BAR_LO : (s == ANIM_HIGH) ? CODE_BAR_HI : CODE_DASH;
    endfunction

    function automatic logic [3:0] ptr_code(input logic [1:0] m);
        return (m == MOTION_UP) ? CODE_UP_PTR : (m == MOTION_DOWN) ? CODE_DN_PTR : CODE_DASH;
    endfunction

    function automatic logic [3:0] floor_code(input logic [2:0] f);
        return (f >= 3'd1 && f <= 3'd4) ? {1'b0, f} : CODE_BLANK;
    endfunction

    function automatic anim_e anim_step(input anim_e s, input logic [1:0] m);
        if (m == MOTION_UP)
            return (s == ANIM_LOW) ? ANIM_MID : (s == ANIM_MID) ? ANIM_HIGH : ANIM_LOW;
        if (m == MOTION_DOWN)
            return (s == ANIM_HIGH) ? ANIM_MID : (s == ANIM_MID) ? ANIM_LOW : ANIM_HIGH;
        return ANIM_MID;
    endfunction

endpackage

// File: rtl/elevator_display_ctrl_if.sv
// elevator_display_ctrl_if: elevator status in, multiplexed display out.
//   floor[2:0], motion[1:0], door_state[1:0] : status from the elevator FSM
//   digit_code[3:0], an[3:0]                  : symbol code and active-low digit enables
//   master = elevator/decoder side, slave = display sequencer.
interface elevator_display_ctrl_if;
    logic [2:0] floor;
    logic [1:0] motion;
    logic [1:0] door_state;
    logic [3:0] digit_code;
    logic [3:0] an;
    modport master (output floor, motion, door_state, input digit_code, an);
    modport slave (input floor, motion, door_state, output digit_code, an);
endinterface

// File: rtl/elevator_display_ctrl_tick_gen.sv
// elevator_display_ctrl_tick_gen: one-cycle pulse every N clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count at 0 on the next edge
//   tick_o     : high during the last cycle of each N-cycle period
module elevator_display_ctrl_tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = $clog2(N);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o = (cnt_q == W'(N - 1));
    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/elevator_display_ctrl.sv
// elevator_display_ctrl: sequences floor, direction, motion bar and door glyph
// onto a 4-digit multiplexed seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of elevator_display_ctrl_if (status in, code/an out)
//   Slots: 0 door glyph (live), 1 motion bar, 2 direction pointer, 3 floor.
module elevator_display_ctrl
    import elevator_display_ctrl_pkg::*;
#(
    parameter int SCAN_TICKS = 100000,
    parameter int ANIM_TICKS = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    elevator_display_ctrl_if.slave  bus
);
    logic       scan_tick, anim_tick, load, step;
    logic [1:0] mot;
    logic [1:0] slot_q, slot_d;
    logic [3:0] an_q, an_d, code_q, code_d;
    logic       blink_q, blink_d;
    logic [1:0] mot_prev_q, mot_prev_d;
    logic [2:0] snap_floor_q, snap_floor_d;
    logic [1:0] snap_motion_q, snap_motion_d;
    anim_e      anim_q, anim_d;

    elevator_display_ctrl_tick_gen #(.N(SCAN_TICKS)) u_scan (
        .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .tick_o(scan_tick)
    );

    // A direction load restarts the animation period so the loaded state is held a full step.
    elevator_display_ctrl_tick_gen #(.N(ANIM_TICKS)) u_anim (
        .clk(clk), .rst_n(rst_n), .clr_i(load), .tick_o(anim_tick)
    );

    always_comb begin
        mot        = motion_norm(bus.motion);
        load       = (mot != mot_prev_q) && (mot != MOTION_IDLE);
        step       = anim_tick && !load;
        mot_prev_d = mot;
        anim_d     = anim_q;
        if (mot == MOTION_IDLE) anim_d = ANIM_MID;
        else if (load)          anim_d = (mot == MOTION_UP) ? ANIM_LOW : ANIM_HIGH;
        else if (step)          anim_d = anim_step(anim_q, mot);
        // Steady door states pin the phase so the next blink starts visible.
        blink_d = !bus.door_state[1] ? 1'b0 : (step ? ~blink_q : blink_q);
    end

    always_comb begin
        slot_d        = scan_tick ? slot_q + 2'd1 : slot_q;
        an_d          = an_q;
        code_d        = code_q;
        snap_floor_d  = snap_floor_q;
        snap_motion_d = snap_motion_q;
        if (scan_tick) begin
            an_d   = ~(4'b0001 << slot_d);
            code_d = (slot_d == 2'd0) ? door_code(bus.door_state, blink_q) :
                     (slot_d == 2'd1) ? bar_code(anim_q) :
                     (slot_d == 2'd2) ? ptr_code(snap_motion_q) : floor_code(snap_floor_q);
            if (slot_d == 2'd0) begin
                snap_floor_d  = bus.floor;
                snap_motion_d = mot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= 2'd3;
            an_q          <= 4'b1111;
            code_q        <= CODE_BLANK;
            blink_q       <= 1'b0;
            mot_prev_q    <= MOTION_IDLE;
            snap_floor_q  <= 3'd0;
            snap_motion_q <= MOTION_IDLE;
            anim_q        <= ANIM_MID;
        end else begin
            slot_q        <= slot_d;
            an_q          <= an_d;
            code_q        <= code_d;
            blink_q       <= blink_d;
            mot_prev_q    <= mot_prev_d;
            snap_floor_q  <= snap_floor_d;
            snap_motion_q <= snap_motion_d;
            anim_q        <= anim_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.digit_code = code_q;
endmodule
